tty_text_writer: RTL and testbench
==================================

// Module: tty_text_writer
// PURPOSE
//  Upstream stage of the VGA text display. Decodes CPU bus writes into TTY commands and maintains the cursor.
//  Writes characters into the 80x30 text VRAM that the VGA block scans out.
//  Handles CR, LF, BS, line wrap, hardware scroll and clear-screen; exports the cursor position for display.
// PARAMETERS
//  BASE_ADDR  32'hFFFF_0100  bus base; regs at BASE+0 TXD, BASE+4 CTRL, BASE+8 CURSOR
//  COLS       80             columns per row
//  ROWS       30             rows per screen
//  AW         12             VRAM address width (COLS*ROWS=2400 < 4096)
// PORTS
//  clk_50mhz   in   1   system clock; all logic on rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  Memwrite    in   1   CPU write strobe, one cycle per access
//  Addrin      in   32  CPU byte address
//  BUS         in   32  CPU write data (driven by CPU while Memwrite=1)
//  status      out  32  {30'b0, ovf, busy}
//  vram_addr   out  AW  VRAM port address = row*COLS+col
//  vram_we     out  1   VRAM write enable
//  vram_wdata  out  8   VRAM write data (ASCII)
//  vram_rdata  in   8   VRAM read data, valid 1 cycle after vram_addr
//  cur_col     out  7   cursor column 0..COLS-1
//  cur_row     out  5   cursor row 0..ROWS-1
// BEHAVIOUR
//  Reset: FSM=IDLE, cur_col=0, cur_row=0, vram_we=0, vram_addr=0, vram_wdata=0, busy=0, ovf=0.
//  Accept: Memwrite=1 and Addrin in {BASE+0,+4,+8} and busy=0 -> command latched at edge t, busy=1 from t+1.
//  Other addresses are ignored. A write to those regs while busy=1 is dropped and sets ovf (sticky).
//  TXD (BUS[7:0]):
//  - 0x20..0x7E: PUT cycle t+1 with vram_we=1, wdata=char at cursor addr; col++ at t+2.
//    col==COLS-1 -> col=0, row++.
//  - 0x0D CR: col=0, no VRAM write.
//  - 0x0A LF: col=0, row++.
//  - 0x08 BS: if col>0, col-- and write 0x20 at new col; if col==0, no-op.
//  - Any other code: ignored; busy for exactly one cycle.
//  Row advance from ROWS-1 -> SCROLL, row stays ROWS-1.
//  CTRL: BUS[0]=1 -> CLEAR_ALL (2400 writes of 0x20, cursor 0,0 at end); BUS[1]=1 clears ovf.
//    Both bits may be set together.
//  CURSOR: col=BUS[6:0], row=BUS[12:8]; values >=COLS/ROWS are clamped to COLS-1/ROWS-1; no VRAM access.
//  FSM: IDLE -> PUT | SCROLL_RD <-> SCROLL_WR -> CLR_LINE | CLR_ALL -> IDLE.
//  SCROLL: for i=0..(ROWS-1)*COLS-1:
//    - SCROLL_RD: addr=i+COLS.
//    - SCROLL_WR: addr=i, we=1, wdata=vram_rdata.
//    2 cycles/char, 4640 cycles total.
//  CLR_LINE: write 0x20 at (ROWS-1)*COLS..ROWS*COLS-1, 80 cycles.
//  busy deasserts the cycle after the last write. vram_we is never high in IDLE or SCROLL_RD.
//  Printable at col=COLS-1,row=ROWS-1: char written, then scroll, cursor ends (0,ROWS-1).
//  rst_n low mid-scroll/clear: abort immediately, all regs to reset values; VRAM keeps partial content.
//  Sole VRAM writer; VGA reads via the other VRAM port. Address arithmetic is AW-bit, never exceeds 2399.
// STRUCTURE
//  tty_defs.vh: COLS, ROWS, AW, reg offsets, ASCII CR/LF/BS/SPACE, FSM state encodings.
//  One sub-module: tty_cursor (col/row counters; inc/wrap, dec, cr, lf, load+clamp; raises scroll_req).
//  Top holds bus decode, FSM, scroll/clear address counter and VRAM port mux.
// TESTING
//  1. Reset, write TXD 0x41 -> vram_we at addr 0 data 0x41 one cycle later; cursor (1,0); busy 1 cycle.
//  2. Cursor (79,5), TXD 0x42 -> write addr 479 = 0x42; cursor (0,6).
//  3. Preload row r with char 'a'+r, cursor (3,29), TXD 0x0A -> after 4720 busy cycles:
//     row r holds 'a'+r+1 (r<29), row 29 all 0x20, cursor (0,29).
//  4. Cursor (0,2), BS -> no write, cursor unchanged; cursor (5,2), BS -> write 0x20 at addr 164, cursor (4,2).
//  5. CTRL=1 then TXD during clear -> write dropped, ovf=1; after 2400 writes all 0x20, cursor (0,0); CTRL=2 -> ovf=0.
//  6. Assert rst_n=0 mid-scroll -> busy=0, cursor (0,0), vram_we=0 same cycle; next TXD is accepted normally.

Source files
------------

// File: rtl/tty_text_writer_pkg.sv
// Shared constants for the TTY text writer: screen geometry, register offsets,
// ASCII control codes and FSM state encodings.
package tty_text_writer_pkg;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int AW   = 12;

  localparam logic [31:0] REG_TXD    = 32'h0000_0000;
  localparam logic [31:0] REG_CTRL   = 32'h0000_0004;
  localparam logic [31:0] REG_CURSOR = 32'h0000_0008;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PUT       = 3'd1;
  localparam logic [2:0] ST_SCROLL_RD = 3'd2;
  localparam logic [2:0] ST_SCROLL_WR = 3'd3;
  localparam logic [2:0] ST_CLR_LINE  = 3'd4;
  localparam logic [2:0] ST_CLR_ALL   = 3'd5;

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    logic [AW-1:0] r;
    r = AW'(row);
    return r * AW'(COLS) + AW'(col);
  endfunction

endpackage

// File: rtl/tty_text_writer_cursor.sv
// Cursor column/row counters with wrap, backspace, CR/LF and clamped load.
// scroll_req flags a row advance requested while already on the last row.
module tty_text_writer_cursor
  import tty_text_writer_pkg::*;
(
  input  logic       clk_50mhz,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       cr,
  input  logic       lf,
  input  logic       load,
  input  logic       home,
  input  logic [6:0] load_col,
  input  logic [4:0] load_row,
  output logic [6:0] col,
  output logic [4:0] row,
  output logic       scroll_req
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  assign scroll_req = (lf || (inc && col == LAST_COL)) && row == LAST_ROW;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (home) begin
      col <= '0;
      row <= '0;
    end else if (load) begin
      col <= (load_col > LAST_COL) ? LAST_COL : load_col;
      row <= (load_row > LAST_ROW) ? LAST_ROW : load_row;
    end else if (lf) begin
      col <= '0;
      if (row != LAST_ROW) row <= row + 5'd1;
    end else if (cr) begin
      col <= '0;
    end else if (inc) begin
      if (col == LAST_COL) begin
        col <= '0;
        if (row != LAST_ROW) row <= row + 5'd1;
      end else begin
        col <= col + 7'd1;
      end
    end else if (dec && col != 7'd0) begin
      col <= col - 7'd1;
    end
  end

endmodule

// File: rtl/tty_text_writer.sv
// CPU-bus TTY front end: decodes TXD/CTRL/CURSOR writes, runs the put/scroll/clear
// sequencer and is the only writer of the text VRAM.
module tty_text_writer
  import tty_text_writer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0100
) (
  input  logic          clk_50mhz,
  input  logic          rst_n,
  input  logic          Memwrite,
  input  logic [31:0]   Addrin,
  input  logic [31:0]   BUS,
  output logic [31:0]   status,
  output logic [AW-1:0] vram_addr,
  output logic          vram_we,
  output logic [7:0]    vram_wdata,
  input  logic [7:0]    vram_rdata,
  output logic [6:0]    cur_col,
  output logic [4:0]    cur_row
);

  localparam logic [AW-1:0] ROW_STRIDE    = AW'(COLS);
  localparam logic [AW-1:0] LAST_ROW_BASE = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] SCROLL_LAST   = AW'((ROWS - 1) * COLS - 1);
  localparam logic [AW-1:0] LINE_LAST     = AW'(COLS - 1);
  localparam logic [AW-1:0] SCREEN_LAST   = AW'(ROWS * COLS - 1);

  logic [2:0]    state;
  logic [AW-1:0] idx;
  logic [AW-1:0] p_addr;
  logic [7:0]    p_data;
  logic          p_we;
  logic          p_adv;
  logic          ovf;
  logic          busy;

  logic          hit_txd, hit_ctrl, hit_cur, hit, accept;
  logic [7:0]    txd;
  logic          printable;
  logic          c_inc, c_dec, c_cr, c_lf, c_load, c_home, scroll_req;
  logic [AW-1:0] cur_addr;
  logic          unused_bus;

  assign hit_txd   = Memwrite && Addrin == BASE_ADDR + REG_TXD;
  assign hit_ctrl  = Memwrite && Addrin == BASE_ADDR + REG_CTRL;
  assign hit_cur   = Memwrite && Addrin == BASE_ADDR + REG_CURSOR;
  assign hit       = hit_txd || hit_ctrl || hit_cur;
  assign busy      = state != ST_IDLE;
  assign accept    = hit && !busy;
  assign txd       = BUS[7:0];
  assign printable = txd >= ASCII_SPACE && txd <= ASCII_TILDE;
  assign cur_addr  = cell_addr(cur_row, cur_col);
  assign status    = {30'b0, ovf, busy};
  assign unused_bus = ^BUS[31:13];

  // Control codes act on the cursor in the accept cycle; printables advance after their write.
  assign c_lf   = accept && hit_txd && txd == ASCII_LF;
  assign c_cr   = accept && hit_txd && txd == ASCII_CR;
  assign c_dec  = accept && hit_txd && txd == ASCII_BS;
  assign c_load = accept && hit_cur;
  assign c_inc  = state == ST_PUT && p_adv;
  assign c_home = state == ST_CLR_ALL && idx == SCREEN_LAST;

  tty_text_writer_cursor u_cursor (
    .clk_50mhz  (clk_50mhz),
    .rst_n      (rst_n),
    .inc        (c_inc),
    .dec        (c_dec),
    .cr         (c_cr),
    .lf         (c_lf),
    .load       (c_load),
    .home       (c_home),
    .load_col   (BUS[6:0]),
    .load_row   (BUS[12:8]),
    .col        (cur_col),
    .row        (cur_row),
    .scroll_req (scroll_req)
  );

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      p_addr <= '0;
      p_data <= '0;
      p_we   <= 1'b0;
      p_adv  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (hit && busy) ovf <= 1'b1;
      else if (accept && hit_ctrl && BUS[1]) ovf <= 1'b0;

      case (state)
        ST_IDLE: if (accept) begin
          state  <= ST_PUT;
          p_we   <= 1'b0;
          p_adv  <= 1'b0;
          p_addr <= cur_addr;
          p_data <= txd;
          if (hit_txd) begin
            if (printable) begin
              p_we  <= 1'b1;
              p_adv <= 1'b1;
            end else if (txd == ASCII_LF && scroll_req) begin
              state <= ST_SCROLL_RD;
              idx   <= '0;
            end else if (txd == ASCII_BS && cur_col != 7'd0) begin
              p_we   <= 1'b1;
              p_addr <= cur_addr - AW'(1);
              p_data <= ASCII_SPACE;
            end
          end else if (hit_ctrl && BUS[0]) begin
            state <= ST_CLR_ALL;
            idx   <= '0;
          end
        end
        ST_PUT: begin
          p_we  <= 1'b0;
          p_adv <= 1'b0;
          if (p_adv && scroll_req) begin
            state <= ST_SCROLL_RD;
            idx   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SCROLL_RD: state <= ST_SCROLL_WR;
        ST_SCROLL_WR: begin
          if (idx == SCROLL_LAST) begin
            idx   <= '0;
            state <= ST_CLR_LINE;
          end else begin
            idx   <= idx + AW'(1);
            state <= ST_SCROLL_RD;
          end
        end
        ST_CLR_LINE: begin
          if (idx == LINE_LAST) begin
            idx   <= '0;
            state <= ST_IDLE;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        ST_CLR_ALL: begin
          if (idx == SCREEN_LAST) begin
            idx   <= '0;
            state <= ST_IDLE;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // VRAM port mux; scroll copies the synchronous read data straight back one row up.
  always_comb begin
    vram_addr  = '0;
    vram_we    = 1'b0;
    vram_wdata = '0;
    case (state)
      ST_PUT: begin
        vram_addr  = p_addr;
        vram_we    = p_we;
        vram_wdata = p_data;
      end
      ST_SCROLL_RD: vram_addr = idx + ROW_STRIDE;
      ST_SCROLL_WR: begin
        vram_addr  = idx;
        vram_we    = 1'b1;
        vram_wdata = vram_rdata;
      end
      ST_CLR_LINE: begin
        vram_addr  = LAST_ROW_BASE + idx;
        vram_we    = 1'b1;
        vram_wdata = ASCII_SPACE;
      end
      ST_CLR_ALL: begin
        vram_addr  = idx;
        vram_we    = 1'b1;
        vram_wdata = ASCII_SPACE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tty_text_writer.sv
// Directed bench for tty_text_writer with a behavioural synchronous-read VRAM.
module tb_tty_text_writer;

  localparam logic [31:0] BASE = 32'hFFFF_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Memwrite = 1'b0;
  logic [31:0] Addrin = '0;
  logic [31:0] BUS = '0;
  logic [31:0] status;
  logic [11:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;

  logic [7:0]  mem [0:4095];
  logic        preload = 1'b0;
  int          wr_count = 0;

  int checks = 0;
  int failures = 0;
  int cyc, w0, errs;
  logic [7:0] exp_ch;

  tty_text_writer dut (
    .clk_50mhz  (clk),
    .rst_n      (rst_n),
    .Memwrite   (Memwrite),
    .Addrin     (Addrin),
    .BUS        (BUS),
    .status     (status),
    .vram_addr  (vram_addr),
    .vram_we    (vram_we),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata),
    .cur_col    (cur_col),
    .cur_row    (cur_row)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2400; i++) mem[i] <= 8'h61 + 8'(i / 80);
    end else if (vram_we) begin
      mem[vram_addr] <= vram_wdata;
    end
    if (vram_we) wr_count <= wr_count + 1;
    vram_rdata <= mem[vram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Memwrite = 1'b1;
    Addrin   = a;
    BUS      = d;
    @(negedge clk);
    Memwrite = 1'b0;
    Addrin   = '0;
    BUS      = '0;
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (status[0] === 1'b1 && cycles < budget) begin
      cycles++;
      @(negedge clk);
    end
    check("idle_within_budget", {31'b0, status[0]}, 32'd0);
  endtask

  task automatic set_cursor(input int col, input int row);
    bus_write(BASE + 8, 32'(row << 8) | 32'(col));
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_status", status, 32'd0);
    check("rst_we", {31'b0, vram_we}, 32'd0);
    check("rst_addr", {20'b0, vram_addr}, 32'd0);
    check("rst_wdata", {24'b0, vram_wdata}, 32'd0);
    check("rst_cursor", {20'b0, cur_row, cur_col}, 32'd0);
    rst_n = 1'b1;

    // printable at home
    bus_write(BASE, 32'h41);
    check("put_we", {31'b0, vram_we}, 32'd1);
    check("put_addr", {20'b0, vram_addr}, 32'd0);
    check("put_data", {24'b0, vram_wdata}, 32'h41);
    check("put_busy", status, 32'd1);
    @(negedge clk);
    check("put_busy_done", status, 32'd0);
    check("put_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd0, 7'd1});
    check("put_mem", {24'b0, mem[0]}, 32'h41);

    // end-of-line wrap
    set_cursor(79, 5);
    check("load_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd5, 7'd79});
    bus_write(BASE, 32'h42);
    check("wrap_we", {31'b0, vram_we}, 32'd1);
    check("wrap_addr", {20'b0, vram_addr}, 32'd479);
    check("wrap_data", {24'b0, vram_wdata}, 32'h42);
    @(negedge clk);
    check("wrap_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd6, 7'd0});

    // ignored address and unprintable code
    bus_write(BASE + 12, 32'h45);
    check("ignored_addr_busy", status, 32'd0);
    bus_write(BASE, 32'h01);
    check("other_code_busy", status, 32'd1);
    check("other_code_we", {31'b0, vram_we}, 32'd0);
    @(negedge clk);
    check("other_code_one_cycle", status, 32'd0);
    check("other_code_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd6, 7'd0});

    // CR and non-scrolling LF
    set_cursor(10, 3);
    bus_write(BASE, 32'h0D);
    @(negedge clk);
    check("cr_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd3, 7'd0});
    set_cursor(7, 3);
    bus_write(BASE, 32'h0A);
    @(negedge clk);
    check("lf_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd4, 7'd0});

    // backspace at column 0 and mid-line
    set_cursor(0, 2);
    bus_write(BASE, 32'h08);
    check("bs0_we", {31'b0, vram_we}, 32'd0);
    @(negedge clk);
    check("bs0_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd2, 7'd0});
    set_cursor(5, 2);
    bus_write(BASE, 32'h08);
    check("bs_we", {31'b0, vram_we}, 32'd1);
    check("bs_addr", {20'b0, vram_addr}, 32'd164);
    check("bs_data", {24'b0, vram_wdata}, 32'h20);
    @(negedge clk);
    check("bs_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd2, 7'd4});

    // clamped cursor load
    set_cursor(127, 31);
    check("clamp_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd29, 7'd79});

    // LF on last row scrolls
    @(negedge clk); preload = 1'b1;
    @(negedge clk); preload = 1'b0;
    set_cursor(3, 29);
    w0 = wr_count;
    bus_write(BASE, 32'h0A);
    wait_idle(6000, cyc);
    check("scroll_busy_cycles", 32'(cyc), 32'd4720);
    check("scroll_writes", 32'(wr_count - w0), 32'd2400);
    errs = 0;
    for (int i = 0; i < 2400; i++) begin
      exp_ch = (i < 2320) ? 8'h62 + 8'(i / 80) : 8'h20;
      if (mem[i] !== exp_ch) errs++;
    end
    check("scroll_content_errs", 32'(errs), 32'd0);
    check("scroll_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd29, 7'd0});

    // printable in bottom-right corner: write then scroll
    set_cursor(79, 29);
    w0 = wr_count;
    bus_write(BASE, 32'h5A);
    check("corner_addr", {20'b0, vram_addr}, 32'd2399);
    wait_idle(6000, cyc);
    check("corner_busy_cycles", 32'(cyc), 32'd4721);
    check("corner_writes", 32'(wr_count - w0), 32'd2401);
    check("corner_moved_char", {24'b0, mem[2319]}, 32'h5A);
    check("corner_last_cell", {24'b0, mem[2399]}, 32'h20);
    check("corner_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd29, 7'd0});

    // clear screen, dropped write sets ovf, CTRL bit1 clears it
    w0 = wr_count;
    bus_write(BASE + 4, 32'h1);
    check("clr_busy", status, 32'd1);
    bus_write(BASE, 32'h43);
    check("ovf_set", status, 32'd3);
    wait_idle(3000, cyc);
    check("clr_writes", 32'(wr_count - w0), 32'd2400);
    errs = 0;
    for (int i = 0; i < 2400; i++) if (mem[i] !== 8'h20) errs++;
    check("clr_content_errs", 32'(errs), 32'd0);
    check("clr_cursor", {20'b0, cur_row, cur_col}, 32'd0);
    check("ovf_sticky", status, 32'd2);
    bus_write(BASE + 4, 32'h2);
    check("ovf_cleared", status, 32'd1);
    @(negedge clk);
    check("ovf_clear_done", status, 32'd0);

    // asynchronous reset during scroll
    set_cursor(0, 29);
    bus_write(BASE, 32'h0A);
    repeat (100) @(negedge clk);
    check("midscroll_busy", status, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_status", status, 32'd0);
    check("abort_we", {31'b0, vram_we}, 32'd0);
    check("abort_cursor", {20'b0, cur_row, cur_col}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_write(BASE, 32'h44);
    check("after_rst_we", {31'b0, vram_we}, 32'd1);
    check("after_rst_addr", {20'b0, vram_addr}, 32'd0);
    check("after_rst_data", {24'b0, vram_wdata}, 32'h44);
    @(negedge clk);
    check("after_rst_cursor", {20'b0, cur_row, cur_col}, {20'b0, 5'd0, 7'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
